// File: rtl/sync_fifo_param_if.sv
// Bus bundle for sync_fifo_param: flush, write/read handshake, read data and status flags.
// The master modport is the producer/consumer side; the slave modport is the FIFO itself.
interface sync_fifo_param_if #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             clr;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic [CW-1:0]    count;
    logic             full;
    logic             almost_full;
    logic             empty;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output clr, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, count, full, almost_full, empty, almost_empty,
               overflow, underflow
    );

    modport slave (
        input  clr, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, count, full, almost_full, empty, almost_empty,
               overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Synchronous FIFO with arbitrary (non power-of-two) depth, registered read data,
// occupancy counter and inclusive almost-full / almost-empty flags.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_PARAM_ERR_EN is defined;
// otherwise both flags are tied low and rejected requests are silently dropped.
module sync_fifo_param #(
    parameter int WIDTH    = 128,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 2
) (
    input  logic               clk,
    input  logic               rst,
    sync_fifo_param_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;

    logic             w_full;
    logic             w_empty;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [PW-1:0]    w_rd_ptr_nxt;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
    assign w_rd_acc = bus.rd_en && !w_empty && !bus.clr;
    assign w_wr_acc = bus.wr_en && (!w_full || w_rd_acc) && !bus.clr;

    // Explicit wrap so the depth need not be a power of two.
    assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

    // Storage array: written on accepted writes only, never reset or flushed.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    // Pointers and occupancy; flush returns to the empty state without touching storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered read port: rd_data holds between reads, rd_valid pulses per accepted read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rd_ptr];
            end
        end
    end

    assign bus.rd_data      = r_rd_data;
    assign bus.rd_valid     = r_rd_valid;
    assign bus.count        = r_count;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= CW'(AF_LEVEL));
    assign bus.almost_empty = (r_count <= CW'(AE_LEVEL));

`ifdef SYNC_FIFO_PARAM_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error capture; outside a flush a write can only be rejected for being full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.clr) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.wr_en && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end
            if (bus.rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1): directed scenarios
// followed by random traffic, every cycle compared against a queue-based reference model.
module tb_sync_fifo_param;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic clk;
    logic rst;

    sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    sync_fifo_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_rd_data;
    logic             m_valid;
    logic             m_ovf;
    logic             m_unf;

`ifdef SYNC_FIFO_PARAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rd_data = '0;
        m_valid   = 1'b0;
        m_ovf     = 1'b0;
        m_unf     = 1'b0;
    endtask

    // One clock of the reference behaviour, evaluated from the pre-edge state.
    task automatic model_step(input logic c, input logic w, input logic r, input logic [WIDTH-1:0] d);
        bit rd_ok;
        bit wr_ok;
        int sz;
        sz = m_q.size();
        if (c) begin
            m_q.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            rd_ok = r && (sz > 0);
            wr_ok = w && ((sz < DEPTH) || rd_ok);
            m_valid = rd_ok;
            if (rd_ok) m_rd_data = m_q.pop_front();
            if (wr_ok) m_q.push_back(d);
            if (ERR_EN && w && !wr_ok) m_ovf = 1'b1;
            if (ERR_EN && r && sz == 0) m_unf = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = m_q.size();
        chk({tag, ".rd_data"}, 32'(bus.rd_data), 32'(m_rd_data));
        chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(m_valid));
        chk({tag, ".count"}, 32'(bus.count), 32'(sz));
        chk({tag, ".full"}, 32'(bus.full), 32'(sz == DEPTH));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(sz == 0));
        chk({tag, ".afull"}, 32'(bus.almost_full), 32'(sz >= AF));
        chk({tag, ".aempty"}, 32'(bus.almost_empty), 32'(sz <= AE));
        chk({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(bus.underflow), 32'(m_unf));
    endtask

    task automatic step(input string tag, input logic c, input logic w, input logic r,
                        input logic [WIDTH-1:0] d);
        @(negedge clk);
        bus.clr     = c;
        bus.wr_en   = w;
        bus.rd_en   = r;
        bus.wr_data = d;
        model_step(c, w, r, d);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        bus.clr     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_data = '0;
    endtask

    initial begin
        logic [WIDTH-1:0] seq [4];
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;

        idle_inputs();
        rst = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Fill then drain in order
        for (int i = 0; i < 4; i++) step("fill", 1'b0, 1'b1, 1'b0, seq[i]);
        chk("fill4.full", 32'(bus.full), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step("drain", 1'b0, 1'b0, 1'b1, 8'h00);
            chk("drain.data_const", 32'(bus.rd_data), 32'(seq[i]));
        end
        step("drain_idle", 1'b0, 1'b0, 1'b0, 8'h00);

        // Overflow on full, then drain
        for (int i = 0; i < 4; i++) step("ovf_fill", 1'b0, 1'b1, 1'b0, seq[i]);
        step("ovf_w55", 1'b0, 1'b1, 1'b0, 8'h55);
        chk("ovf.count_const", 32'(bus.count), 32'd4);
        chk("ovf.flag_const", 32'(bus.overflow), 32'(ERR_EN));
        for (int i = 0; i < 4; i++) step("ovf_drain", 1'b0, 1'b0, 1'b1, 8'h00);
        step("ovf_clr", 1'b1, 1'b0, 1'b0, 8'h00);

        // Simultaneous read/write while empty
        step("empty_rw", 1'b0, 1'b1, 1'b1, 8'hA5);
        chk("empty_rw.valid_const", 32'(bus.rd_valid), 32'd0);
        chk("empty_rw.unf_const", 32'(bus.underflow), 32'(ERR_EN));
        step("empty_rw_rd", 1'b0, 1'b0, 1'b1, 8'h00);
        chk("empty_rw.data_const", 32'(bus.rd_data), 32'hA5);

        // Full pass-through across pointer wrap
        for (int i = 0; i < 4; i++) step("wrap_fill", 1'b0, 1'b1, 1'b0, seq[i]);
        for (int i = 0; i < 6; i++) step("wrap_rw", 1'b0, 1'b1, 1'b1, 8'h66);
        for (int i = 0; i < 4; i++) step("wrap_drain", 1'b0, 1'b0, 1'b1, 8'h00);
        chk("wrap.last_const", 32'(bus.rd_data), 32'h66);

        // Flush with a concurrent write, then async reset mid-burst
        for (int i = 0; i < 3; i++) step("clr_fill", 1'b0, 1'b1, 1'b0, seq[i]);
        step("clr_pulse", 1'b1, 1'b1, 1'b0, 8'h77);
        chk("clr.empty_const", 32'(bus.empty), 32'd1);
        for (int i = 0; i < 3; i++) step("burst", 1'b0, 1'b1, (i == 2), seq[i]);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h99;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        step("post_rst_w", 1'b0, 1'b1, 1'b0, 8'hC3);
        step("post_rst_r", 1'b0, 1'b0, 1'b1, 8'h00);
        chk("post_rst.data_const", 32'(bus.rd_data), 32'hC3);

        // Random traffic in phases biased toward filling, draining and balanced use
        for (int p = 0; p < 6; p++) begin
            int wpct;
            int rpct;
            wpct = (p % 3 == 0) ? 80 : (p % 3 == 1) ? 20 : 50;
            rpct = 100 - wpct;
            for (int i = 0; i < 300; i++) begin
                step("rand",
                     ($urandom_range(0, 99) < 3),
                     ($urandom_range(0, 99) < wpct),
                     ($urandom_range(0, 99) < rpct),
                     WIDTH'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
